// File: rtl/hack_mem_arbiter.sv
// Two-master arbiter in front of the single hack_memory port.
// One access per IDLE->BUSY pass; illegal accesses are suppressed and flagged with err alongside ack.
module hack_mem_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int KBD_ADDR      = 24576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [14:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [14:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic [14:0] mem_address,
  output logic [15:0] mem_in,
  output logic        mem_load,
  input  logic [15:0] mem_out
);

  localparam logic [14:0] LP_KBD = 15'(KBD_ADDR);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             r_state, w_next;
  logic [1:0]         w_req, w_we, w_elig, r_ack;
  logic [1:0][14:0]   w_addr;
  logic [1:0][15:0]   w_wdata;
  logic               w_grant, w_sel;
  logic               r_sel, r_last_sel, r_we;
  logic [14:0]        r_addr;
  logic [15:0]        r_wdata;
  logic               w_in_map, w_wr_ok, w_illegal;

  assign w_req   = {m1_req, m0_req};
  assign w_we    = {m1_we, m0_we};
  assign w_addr  = {m1_addr, m0_addr};
  assign w_wdata = {m1_wdata, m0_wdata};

  // A master being acked this cycle already had its request served.
  assign w_elig = w_req & ~r_ack;

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_sel   = 1'b0;
    if (r_state == IDLE) begin
      if (|w_elig) begin
        w_grant = 1'b1;
        w_next  = BUSY;
        if (w_elig == 2'b10)
          w_sel = 1'b1;
        else if (w_elig == 2'b11 && PRIORITY_MODE == 0)
          w_sel = ~r_last_sel;
      end
    end else begin
      w_next = IDLE;
    end
  end

  assign w_in_map  = (r_addr <= LP_KBD);
  assign w_wr_ok   = r_we & (r_addr < LP_KBD);
  assign w_illegal = ~w_in_map | (r_we & (r_addr == LP_KBD));

  // Address/data come straight from the latch so they hold steady through IDLE.
  assign mem_address = r_addr;
  assign mem_in      = r_wdata;
  assign mem_load    = (r_state == BUSY) & w_wr_ok;

  assign m0_ack = r_ack[0];
  assign m1_ack = r_ack[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_sel <= 1'b1;
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ack      <= '0;
      err        <= 1'b0;
      rdata      <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      if (w_grant) begin
        r_sel      <= w_sel;
        r_last_sel <= w_sel;
        r_we       <= w_we[w_sel];
        r_addr     <= w_addr[w_sel];
        r_wdata    <= w_wdata[w_sel];
      end
      if (r_state == BUSY) begin
        rdata        <= w_in_map ? mem_out : 16'h0000;
        r_ack[r_sel] <= 1'b1;
        err          <= w_illegal;
      end
    end
  end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Bench for hack_mem_arbiter: a round-robin and a fixed-priority instance share master inputs,
// each with its own memory; a shadow memory predicts read data, err and write effects.
module tb_hack_mem_arbiter;

  localparam logic [14:0] KBD = 15'd24576;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [14:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;

  logic        a_ack0, a_ack1, a_err, a_load;
  logic [15:0] a_rdata, a_in, a_out;
  logic [14:0] a_addr;
  logic        b_ack0, b_ack1, b_err, b_load;
  logic [15:0] b_rdata, b_in, b_out;
  logic [14:0] b_addr;

  logic [15:0] mem_a  [0:32767];
  logic [15:0] mem_b  [0:32767];
  logic [15:0] shadow [0:32767];

  int n_assert = 0;
  int n_fail   = 0;

  hack_mem_arbiter #(.PRIORITY_MODE(0), .KBD_ADDR(24576)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(a_ack0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(a_ack1),
    .rdata(a_rdata), .err(a_err), .mem_address(a_addr), .mem_in(a_in), .mem_load(a_load),
    .mem_out(a_out));

  hack_mem_arbiter #(.PRIORITY_MODE(1), .KBD_ADDR(24576)) u_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(b_ack0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(b_ack1),
    .rdata(b_rdata), .err(b_err), .mem_address(b_addr), .mem_in(b_in), .mem_load(b_load),
    .mem_out(b_out));

  // hack_memory stand-ins: combinational read, write on the rising edge
  assign a_out = mem_a[a_addr];
  assign b_out = mem_b[b_addr];
  always @(posedge clk) begin
    if (a_load) mem_a[a_addr] <= a_in;
    if (b_load) mem_b[b_addr] <= b_in;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic rq, input logic we,
                       input logic [14:0] ad, input logic [15:0] wd);
    if (m == 0) begin
      m0_req = rq; m0_we = we; m0_addr = ad; m0_wdata = wd;
    end else begin
      m1_req = rq; m1_we = we; m1_addr = ad; m1_wdata = wd;
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [14:0] ad);
    return (ad <= KBD) ? shadow[ad] : 16'h0000;
  endfunction

  function automatic logic exp_err(input logic we, input logic [14:0] ad);
    return (ad > KBD) || (we && ad == KBD);
  endfunction

  // Single access from one master with the other idle; both instances must agree.
  task automatic acc(input int m, input logic we, input logic [14:0] ad,
                     input logic [15:0] wd, input string tag);
    logic [15:0] er;
    logic        ee, el;
    logic [1:0]  av;
    er = exp_rd(ad);
    ee = exp_err(we, ad);
    el = we && (ad < KBD);
    av = (m == 0) ? 2'b01 : 2'b10;
    drive(m, 1'b1, we, ad, wd);
    step();
    chk({tag, " busy rr"}, {a_ack1, a_ack0, a_load}, {2'b00, el});
    chk({tag, " busy fp"}, {b_ack1, b_ack0, b_load}, {2'b00, el});
    step();
    chk({tag, " ack rr"}, {a_ack1, a_ack0, a_err, a_load, a_rdata, a_addr}, {av, ee, 1'b0, er, ad});
    chk({tag, " ack fp"}, {b_ack1, b_ack0, b_err, b_load, b_rdata, b_addr}, {av, ee, 1'b0, er, ad});
    drive(m, 1'b0, 1'b0, 15'd0, 16'd0);
    if (el) shadow[ad] = wd;
    step();
    chk({tag, " clear rr"}, {a_ack1, a_ack0, a_err, a_rdata}, '0);
  endtask

  // Both masters request reads continuously for n cycles; acks land on even cycles.
  task automatic tie(input string tag, input logic a_first, input logic b_first, input int n);
    logic wa, wb;
    drive(0, 1'b1, 1'b0, 15'd75, 16'd0);
    drive(1, 1'b1, 1'b0, 15'd24000, 16'd0);
    for (int k = 1; k <= n; k++) begin
      step();
      wa = ((k / 2) % 2 == 1) ? a_first : ~a_first;
      wb = ((k / 2) % 2 == 1) ? b_first : ~b_first;
      chk($sformatf("%s rr k%0d", tag, k), {a_ack1, a_ack0},
          (k % 2 == 0) ? (wa ? 2'b10 : 2'b01) : 2'b00);
      chk($sformatf("%s fp k%0d", tag, k), {b_ack1, b_ack0},
          (k % 2 == 0) ? (wb ? 2'b10 : 2'b01) : 2'b00);
    end
    drive(0, 1'b0, 1'b0, 15'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 15'd0, 16'd0);
    step();
    chk({tag, " settle"}, {a_ack1, a_ack0, b_ack1, b_ack0}, '0);
  endtask

  function automatic logic [14:0] rnd_addr();
    case ($urandom_range(0, 4))
      0:       return 15'($urandom_range(0, 15999));
      1:       return 15'($urandom_range(16384, 24575));
      2:       return KBD;
      3:       return 15'($urandom_range(24577, 32767));
      default: return ($urandom_range(0, 1) == 1) ? 15'd75 : 15'd16383;
    endcase
  endfunction

  initial begin
    logic        pend [2];
    logic        pwe  [2];
    logic [14:0] pad  [2];
    logic [15:0] pwd  [2];
    int          age  [2];
    int          loads, wr_legal;
    logic        ackm;

    for (int i = 0; i < 32768; i++) begin
      mem_a[i] = 16'h0; mem_b[i] = 16'h0; shadow[i] = 16'h0;
    end
    mem_a[KBD] = 16'h0041; mem_b[KBD] = 16'h0041; shadow[KBD] = 16'h0041;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 15'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 15'd0, 16'd0);
    step(); step();
    chk("reset rr", {a_ack1, a_ack0, a_err, a_load, a_rdata, a_addr, a_in}, '0);
    chk("reset fp", {b_ack1, b_ack0, b_err, b_load, b_rdata, b_addr, b_in}, '0);
    reset = 1'b0;
    step();
    chk("post reset rr", {a_ack1, a_ack0, a_err, a_load, a_rdata, a_addr, a_in}, '0);

    acc(0, 1'b0, 15'd0,     16'h0000, "m0 rd 0");
    acc(0, 1'b1, 15'd75,    16'hFFFF, "m0 wr 75");
    acc(0, 1'b0, 15'd75,    16'h0000, "m0 rd 75");
    // last winner was m0: round-robin now favours m1, fixed priority still m0
    tie("tie after m0", 1'b1, 1'b0, 8);
    acc(1, 1'b1, KBD,       16'hDEAD, "m1 wr kbd");
    acc(1, 1'b0, 15'd25000, 16'h0000, "m1 rd oob");
    acc(1, 1'b1, 15'd25000, 16'hBEEF, "m1 wr oob");
    acc(1, 1'b1, 15'd24000, 16'h1234, "m1 wr screen");
    acc(0, 1'b0, 15'd24000, 16'h0000, "m0 rd screen");
    acc(0, 1'b0, KBD,       16'h0000, "m0 rd kbd");
    acc(0, 1'b0, 15'd16383, 16'h0000, "m0 rd ram top");

    // reset in the middle of a write's BUSY cycle
    drive(0, 1'b1, 1'b1, 15'd16000, 16'hAAAA);
    step();
    chk("mid busy load", {a_load, b_load}, 2'b11);
    #2 reset = 1'b1;
    #1 chk("async load drop", {a_load, b_load}, 2'b00);
    drive(0, 1'b0, 1'b0, 15'd0, 16'd0);
    step(); step();
    chk("abort no ack rr", {a_ack1, a_ack0, a_err, a_load, a_rdata}, '0);
    chk("abort no ack fp", {b_ack1, b_ack0, b_err, b_load, b_rdata}, '0);
    reset = 1'b0;
    step();
    chk("abort idle rr", {a_ack1, a_ack0, a_load}, '0);
    tie("tie after reset", 1'b0, 1'b0, 2);

    // randomized traffic from both masters against the shadow memory
    loads = 0; wr_legal = 0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; pwe[m] = 1'b0; pad[m] = '0; pwd[m] = '0; age[m] = 0;
    end
    for (int cyc = 0; cyc < 2030; cyc++) begin
      step();
      if (a_load) loads++;
      for (int m = 0; m < 2; m++) begin
        ackm = (m == 0) ? a_ack0 : a_ack1;
        if (!pend[m]) begin
          chk($sformatf("rnd idle ack m%0d", m), ackm, 1'b0);
        end else if (ackm) begin
          chk($sformatf("rnd resp m%0d a%0d", m, pad[m]), {a_err, a_rdata},
              {exp_err(pwe[m], pad[m]), exp_rd(pad[m])});
          if (pwe[m] && pad[m] < KBD) begin
            shadow[pad[m]] = pwd[m];
            wr_legal++;
          end
          pend[m] = 1'b0;
          drive(m, 1'b0, 1'b0, 15'd0, 16'd0);
        end else begin
          age[m]++;
          if (age[m] > 10) begin
            chk($sformatf("rnd timeout m%0d", m), ackm, 1'b1);
            pend[m] = 1'b0;
            drive(m, 1'b0, 1'b0, 15'd0, 16'd0);
          end
        end
        if (!pend[m] && cyc < 2000 && $urandom_range(0, 2) == 0) begin
          pend[m] = 1'b1;
          age[m]  = 0;
          pwe[m]  = ($urandom_range(0, 1) == 1);
          pad[m]  = rnd_addr();
          pwd[m]  = 16'($urandom_range(0, 65535));
          drive(m, 1'b1, pwe[m], pad[m], pwd[m]);
        end
      end
    end
    chk("rnd load count", loads, wr_legal);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
